// File: rtl/munoc_stream_checker_pkg.sv
// Shared constants and width helpers for the munoc stream checker.
// The top and every lane import this package.
package munoc_stream_checker_pkg;

  localparam int MAX_CH = 8;

  // Extra bits above error_count so that one cycle's additions cannot wrap
  // before the saturation check. MAX_CH mismatches fit in 4 bits.
  localparam int BW_ERR_HEADROOM = 4;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/munoc_stream_checker_lane.sv
// One checker channel: expected and actual FIFOs, the repeat and stall
// counters, the masked compare, and the sticky per-channel error bits.
module munoc_stream_checker_lane
  import munoc_stream_checker_pkg::*;
#(
  parameter int                 BW_DATA   = 32,
  parameter int                 DEPTH     = 16,
  parameter int                 BW_REPEAT = 4,
  parameter int                 TIMEOUT   = 1024,
  parameter logic [BW_DATA-1:0] DATA_MASK = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 exp_wvalid,
  output logic                 exp_wready,
  input  logic [BW_DATA-1:0]   exp_wdata,
  input  logic [BW_REPEAT-1:0] exp_wrepeat,
  input  logic                 act_wvalid,
  output logic                 act_wready,
  input  logic [BW_DATA-1:0]   act_wdata,
  output logic                 mismatch,
  output logic [BW_DATA-1:0]   cmp_exp,
  output logic [BW_DATA-1:0]   cmp_act,
  output logic                 error,
  output logic                 timeout
);

  localparam int BW_PTR   = clog2_min1(DEPTH);
  localparam int BW_CNT   = $clog2(DEPTH + 1);
  localparam int BW_STALL = clog2_min1(TIMEOUT + 1);
  localparam logic [BW_PTR-1:0]   LAST_PTR    = BW_PTR'(DEPTH - 1);
  localparam logic [BW_CNT-1:0]   FULL_CNT    = BW_CNT'(DEPTH);
  localparam logic [BW_STALL-1:0] STALL_LIMIT = BW_STALL'(TIMEOUT);

  function automatic logic [BW_PTR-1:0] ptr_inc(input logic [BW_PTR-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  logic [BW_REPEAT+BW_DATA-1:0] exp_mem [DEPTH];
  logic [BW_DATA-1:0]           act_mem [DEPTH];
  logic [BW_PTR-1:0]            exp_wr_ptr, exp_rd_ptr, act_wr_ptr, act_rd_ptr;
  logic [BW_CNT-1:0]            exp_cnt, act_cnt;
  logic [BW_REPEAT-1:0]         rep_cnt, head_rep;
  logic [BW_STALL-1:0]          stall_cnt, stall_next;
  logic                         exp_push, act_push, exp_pop, act_pop;
  logic                         exp_empty, act_empty, fire, match, stall_hit;

  assign exp_empty  = (exp_cnt == '0);
  assign act_empty  = (act_cnt == '0);
  assign exp_wready = enable & ~clear & ~rst & (exp_cnt != FULL_CNT);
  assign act_wready = enable & ~clear & ~rst & (act_cnt != FULL_CNT);
  assign exp_push   = exp_wvalid & exp_wready;
  assign act_push   = act_wvalid & act_wready;

  assign {head_rep, cmp_exp} = exp_mem[exp_rd_ptr];
  assign cmp_act  = act_mem[act_rd_ptr];
  assign fire     = enable & ~clear & ~exp_empty & ~act_empty;
  assign match    = (((cmp_exp ^ cmp_act) & DATA_MASK) == '0);
  assign mismatch = fire & ~match;
  assign act_pop  = fire;
  assign exp_pop  = fire & (~match | (rep_cnt == head_rep));

  // NOTE: FIFO storage carries no reset; the counts alone decide which
  // words are valid, so flushing only has to zero the pointers.
  always_ff @(posedge clk) begin
    if (exp_push) exp_mem[exp_wr_ptr] <= {exp_wrepeat, exp_wdata};
    if (act_push) act_mem[act_wr_ptr] <= act_wdata;
  end

  always_comb begin
    // NOTE: default first so every path assigns stall_next; no latch.
    stall_next = stall_cnt;
    if (enable) begin
      if (fire || (exp_empty && act_empty)) begin
        stall_next = '0;
      end else if ((TIMEOUT != 0) && (stall_cnt != STALL_LIMIT)) begin
        stall_next = stall_cnt + 1'b1;
      end
    end
  end

  assign stall_hit = (TIMEOUT != 0) && enable && (stall_next == STALL_LIMIT);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      exp_wr_ptr <= '0;
      exp_rd_ptr <= '0;
      act_wr_ptr <= '0;
      act_rd_ptr <= '0;
      exp_cnt    <= '0;
      act_cnt    <= '0;
      rep_cnt    <= '0;
      stall_cnt  <= '0;
      error      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (exp_push) exp_wr_ptr <= ptr_inc(exp_wr_ptr);
      if (exp_pop)  exp_rd_ptr <= ptr_inc(exp_rd_ptr);
      if (act_push) act_wr_ptr <= ptr_inc(act_wr_ptr);
      if (act_pop)  act_rd_ptr <= ptr_inc(act_rd_ptr);
      exp_cnt   <= exp_cnt + BW_CNT'(exp_push) - BW_CNT'(exp_pop);
      act_cnt   <= act_cnt + BW_CNT'(act_push) - BW_CNT'(act_pop);
      stall_cnt <= stall_next;
      // A completed entry or a mismatch both restart the repeat count.
      if (fire) rep_cnt <= exp_pop ? '0 : rep_cnt + 1'b1;
      error   <= error | mismatch | stall_hit;
      timeout <= timeout | stall_hit;
    end
  end

endmodule

// File: rtl/munoc_stream_checker.sv
// Multi-channel stream checker: NUM_CH independent lanes plus the shared
// error counter, first-error capture and summary flags.
module munoc_stream_checker
  import munoc_stream_checker_pkg::*;
#(
  parameter int                 BW_DATA   = 32,
  parameter int                 NUM_CH    = 2,
  parameter int                 DEPTH     = 16,
  parameter int                 BW_REPEAT = 4,
  parameter int                 BW_ERRCNT = 16,
  parameter int                 TIMEOUT   = 1024,
  parameter logic [BW_DATA-1:0] DATA_MASK = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [NUM_CH-1:0]             exp_wvalid,
  output logic [NUM_CH-1:0]             exp_wready,
  input  logic [NUM_CH*BW_DATA-1:0]     exp_wdata,
  input  logic [NUM_CH*BW_REPEAT-1:0]   exp_wrepeat,
  input  logic [NUM_CH-1:0]             act_wvalid,
  output logic [NUM_CH-1:0]             act_wready,
  input  logic [NUM_CH*BW_DATA-1:0]     act_wdata,
  output logic                          error_flag,
  output logic [NUM_CH-1:0]             error_ch,
  output logic                          timeout_flag,
  output logic [BW_ERRCNT-1:0]          error_count,
  output logic                          first_err_valid,
  output logic [clog2_min1(NUM_CH)-1:0] first_err_ch,
  output logic [BW_DATA-1:0]            first_err_exp,
  output logic [BW_DATA-1:0]            first_err_act
);

  localparam int BW_CH  = clog2_min1(NUM_CH);
  localparam int BW_SUM = BW_ERRCNT + BW_ERR_HEADROOM;

  logic [NUM_CH-1:0]  mismatch, lane_timeout;
  logic [BW_DATA-1:0] cmp_exp [NUM_CH];
  logic [BW_DATA-1:0] cmp_act [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    munoc_stream_checker_lane #(
      .BW_DATA   (BW_DATA),
      .DEPTH     (DEPTH),
      .BW_REPEAT (BW_REPEAT),
      .TIMEOUT   (TIMEOUT),
      .DATA_MASK (DATA_MASK)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .clear       (clear),
      .exp_wvalid  (exp_wvalid[c]),
      .exp_wready  (exp_wready[c]),
      .exp_wdata   (exp_wdata[c*BW_DATA +: BW_DATA]),
      .exp_wrepeat (exp_wrepeat[c*BW_REPEAT +: BW_REPEAT]),
      .act_wvalid  (act_wvalid[c]),
      .act_wready  (act_wready[c]),
      .act_wdata   (act_wdata[c*BW_DATA +: BW_DATA]),
      .mismatch    (mismatch[c]),
      .cmp_exp     (cmp_exp[c]),
      .cmp_act     (cmp_act[c]),
      .error       (error_ch[c]),
      .timeout     (lane_timeout[c])
    );
  end

  assign error_flag   = |error_ch;
  assign timeout_flag = |lane_timeout;

  logic [BW_ERR_HEADROOM-1:0] mis_cnt;
  logic [BW_SUM-1:0]          err_sum;
  logic [BW_ERRCNT-1:0]       count_next;
  logic                       cap_valid;
  logic [BW_CH-1:0]           cap_ch;
  logic [BW_DATA-1:0]         cap_exp, cap_act;

  always_comb begin
    mis_cnt   = '0;
    cap_valid = 1'b0;
    cap_ch    = '0;
    cap_exp   = '0;
    cap_act   = '0;
    // Walk downward so the lowest mismatching channel is the one left standing.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      mis_cnt = mis_cnt + BW_ERR_HEADROOM'(mismatch[c]);
      if (mismatch[c]) begin
        cap_valid = 1'b1;
        cap_ch    = BW_CH'(c);
        cap_exp   = cmp_exp[c];
        cap_act   = cmp_act[c];
      end
    end
    err_sum    = BW_SUM'(error_count) + BW_SUM'(mis_cnt);
    count_next = (|err_sum[BW_SUM-1:BW_ERRCNT]) ? '1 : err_sum[BW_ERRCNT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
    end else begin
      error_count <= count_next;
      if (cap_valid && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_ch    <= cap_ch;
        first_err_exp   <= cap_exp;
        first_err_act   <= cap_act;
      end
    end
  end

endmodule
